wb_arbiter: RTL
===============

# wb_arbiter

Write-back merger that drives the register file's single write port (WB_EN / WB_Dest / WB_Value). It accepts ALU results from the EXE/MEM path and load data from the memory-side controller, and serialises them through a small in-order FIFO into one write per cycle. It also reports pending-write hazards on two source-register indices to the hazard unit.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- WIDTH, 32, data width
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- mem_valid  in  1  load result present this cycle
- mem_dest  in  4  load destination register
- mem_value  in  WIDTH  load data
- alu_valid  in  1  ALU result present this cycle
- alu_dest  in  4  ALU destination register
- alu_value  in  WIDTH  ALU result
- in_ready  out  1  both producers may present results; producers hold while low
- src1, src2  in  4  register indices queried by the hazard unit
- hazard1, hazard2  out  1  a pending write targets src1 / src2
- WB_EN  out  1  register-file write enable
- WB_Dest  out  4  register-file write index
- WB_Value  out  WIDTH  register-file write data

## Operation
- State:
  - circular FIFO (DEPTH × {dest[3:0], value}), rd_ptr, wr_ptr, count (0..DEPTH);
  - registered output stage (WB_EN, WB_Dest, WB_Value).
- Combinational ready: in_ready = (DEPTH − count) ≥ 2. It depends on state only, not on the same-edge pop.
- Push, at posedge, only when in_ready = 1:
  - mem_valid pushes {mem_dest, mem_value};
  - alu_valid pushes {alu_dest, alu_value};
  - both valid: the mem entry is written first (it is older in program order), then the alu entry; wr_ptr advances by 2.
  - When in_ready = 0, valid inputs are ignored. A producer that drops data violates protocol; this is not checked.
- Pop, at posedge:
  - if count > 0 before the edge: output stage ← head entry, WB_EN ← 1, rd_ptr advances;
  - otherwise WB_EN ← 0, and WB_Dest / WB_Value hold their previous values.
- Count update: count_next = count + pushes − pop. Pushes are 0–2, pop is 0–1. Pointers wrap modulo DEPTH.
- Ordering: writes reach the register file in strict arrival order, so the last write to a register wins.
- Hazard: hazardN = 1 when srcN equals the dest of any occupied FIFO entry, or WB_Dest while WB_EN = 1. Inputs arriving this cycle are not included. Purely combinational.
- Reset values:
  - count = 0, rd_ptr = 0, wr_ptr = 0;
  - WB_EN = 0, WB_Dest = 0, WB_Value = 0;
  - FIFO contents are don't-care, but are never popped while unoccupied.
- Reset mid-operation: all pending writes are discarded immediately and WB_EN drops asynchronously.

## Timing
- Latency: an input accepted at edge N, into an empty FIFO, appears on WB_* after edge N+1.
- The register file commits the write on the following negedge.
- Throughput: 1 write per cycle sustained. A burst of dual pushes fills the FIFO, and in_ready falls once count ≥ DEPTH−1.
- Full boundary: in_ready = 0 at count = DEPTH−1 and at count = DEPTH. The pop continues, so count falls by 1 per cycle until in_ready reasserts.
- Empty boundary: count = 0 with no push gives WB_EN = 0 on the next cycle. A push at an edge where count = 0 is not popped until the following edge (no bypass).
- Simultaneous push 2 / pop 1: net count +1, and the head entry is never the one being written.
- Hazard outputs change in the same cycle as the state; there is no added latency.

## Structure
- Shared package:
  - WB_DEST_W = 4 and WIDTH default;
  - the wb_entry_t struct {dest, value}, also used by the register file and the hazard unit.
- One sub-module: wb_fifo (2-write / 1-read circular buffer exposing count and per-entry dest/occupancy for the hazard compare).
- Arbitration, output stage and hazard compare live in wb_arbiter.

## Test plan
- Reset, then idle → WB_EN = 0, WB_Dest = 0, WB_Value = 0, in_ready = 1, hazard1/2 = 0.
- Single alu push {R3, 0x0000_00AA} at edge 1 → edge 2: WB_EN = 1, WB_Dest = 3, WB_Value = 0xAA; edge 3: WB_EN = 0.
- Same-edge mem {R5, 0x11} and alu {R5, 0x22} → WB writes R5 = 0x11 then R5 = 0x22 on consecutive cycles; final register value 0x22.
- Dual pushes every cycle with DEPTH = 4 → in_ready drops once count ≥ 3; no entry is lost or duplicated; the output sequence matches the input order.
- Hazard query:
  - push {R7, x}, src1 = 7, src2 = 2 → hazard1 = 1 and hazard2 = 0 while the entry is in the FIFO or the output stage;
  - hazard1 = 0 after WB_EN drops.
- Assert rst with 3 entries pending → WB_EN = 0 immediately; after release there are no further writes and count = 0.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared write-back types: register index width, default data width and the
// {dest, value} entry used by the arbiter, register file and hazard unit.
package wb_arbiter_pkg;
   localparam int WB_DEST_W = 4;
   localparam int WB_WIDTH  = 32;

   typedef struct packed {
      logic [WB_DEST_W-1:0] dest;
      logic [WB_WIDTH-1:0]  value;
   } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// 2-write / 1-read circular buffer. Exposes count plus per-entry dest and
// occupancy so the arbiter can run the pending-write hazard compare.
module wb_fifo
   import wb_arbiter_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = WB_WIDTH,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [1:0]                          n_push,
   input  logic [WB_DEST_W-1:0]                in0_dest,
   input  logic [WIDTH-1:0]                    in0_value,
   input  logic [WB_DEST_W-1:0]                in1_dest,
   input  logic [WIDTH-1:0]                    in1_value,
   input  logic                                pop,
   output logic [WB_DEST_W-1:0]                head_dest,
   output logic [WIDTH-1:0]                    head_value,
   output logic [CNT_W-1:0]                    count,
   output logic [DEPTH-1:0]                    occ,
   output logic [DEPTH-1:0][WB_DEST_W-1:0]     ent_dest
);
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, wr_ptr_p1;
   logic [CNT_W-1:0] count_q, count_d;
   logic [DEPTH-1:0][WB_DEST_W-1:0] dest_q, dest_d;
   logic [DEPTH-1:0][WIDTH-1:0]     value_q, value_d;

   // in0 is always the older entry; in1 is only used on a dual push
   always_comb begin
      dest_d    = dest_q;
      value_d   = value_q;
      wr_ptr_p1 = wr_ptr_q + PTR_W'(1);
      if (n_push != 2'd0) begin
         dest_d[wr_ptr_q]  = in0_dest;
         value_d[wr_ptr_q] = in0_value;
      end
      if (n_push == 2'd2) begin
         dest_d[wr_ptr_p1]  = in1_dest;
         value_d[wr_ptr_p1] = in1_value;
      end
      wr_ptr_d = wr_ptr_q + PTR_W'(n_push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_W'(n_push) - CNT_W'(pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      dest_q  <= dest_d;
      value_q <= value_d;
   end

   assign head_dest  = dest_q[rd_ptr_q];
   assign head_value = value_q[rd_ptr_q];
   assign count      = count_q;
   assign ent_dest   = dest_q;

   // slot i is live when its distance from the head is below count
   for (genvar i = 0; i < DEPTH; i++) begin : g_occ
      logic [PTR_W-1:0] off;
      assign off    = PTR_W'(i) - rd_ptr_q;
      assign occ[i] = CNT_W'(off) < count_q;
   end
endmodule

// File: rtl/wb_arbiter.sv
// Write-back merger: serialises load and ALU results into one register-file
// write per cycle and flags pending writes to the queried source registers.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = WB_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mem_valid,
   input  logic [WB_DEST_W-1:0] mem_dest,
   input  logic [WIDTH-1:0]     mem_value,
   input  logic                 alu_valid,
   input  logic [WB_DEST_W-1:0] alu_dest,
   input  logic [WIDTH-1:0]     alu_value,
   output logic                 in_ready,
   input  logic [WB_DEST_W-1:0] src1,
   input  logic [WB_DEST_W-1:0] src2,
   output logic                 hazard1,
   output logic                 hazard2,
   output logic                 WB_EN,
   output logic [WB_DEST_W-1:0] WB_Dest,
   output logic [WIDTH-1:0]     WB_Value
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [1:0]                      n_push;
   logic                            pop;
   logic [WB_DEST_W-1:0]            in0_dest, head_dest;
   logic [WIDTH-1:0]                in0_value, head_value;
   logic [CNT_W-1:0]                count;
   logic [DEPTH-1:0]                occ;
   logic [DEPTH-1:0][WB_DEST_W-1:0] ent_dest;

   logic                 wb_en_q, wb_en_d;
   logic [WB_DEST_W-1:0] wb_dest_q, wb_dest_d;
   logic [WIDTH-1:0]     wb_value_q, wb_value_d;

   // ready looks at state only, so a dual push always fits even without a pop
   assign in_ready = count <= CNT_W'(DEPTH - 2);
   assign pop      = count != '0;

   // mem is older in program order, so it takes the first slot when present
   always_comb begin
      in0_dest  = mem_valid ? mem_dest  : alu_dest;
      in0_value = mem_valid ? mem_value : alu_value;
      n_push    = 2'd0;
      if (in_ready)
         n_push = 2'(mem_valid) + 2'(alu_valid);
   end

   wb_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .n_push    (n_push),
      .in0_dest  (in0_dest),
      .in0_value (in0_value),
      .in1_dest  (alu_dest),
      .in1_value (alu_value),
      .pop       (pop),
      .head_dest (head_dest),
      .head_value(head_value),
      .count     (count),
      .occ       (occ),
      .ent_dest  (ent_dest)
   );

   always_comb begin
      wb_en_d    = pop;
      wb_dest_d  = wb_dest_q;
      wb_value_d = wb_value_q;
      if (pop) begin
         wb_dest_d  = head_dest;
         wb_value_d = head_value;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_en_q    <= 1'b0;
         wb_dest_q  <= '0;
         wb_value_q <= '0;
      end else begin
         wb_en_q    <= wb_en_d;
         wb_dest_q  <= wb_dest_d;
         wb_value_q <= wb_value_d;
      end
   end

   // incoming results this cycle are deliberately not part of the compare
   always_comb begin
      hazard1 = wb_en_q && (wb_dest_q == src1);
      hazard2 = wb_en_q && (wb_dest_q == src2);
      for (int i = 0; i < DEPTH; i++) begin
         if (occ[i] && ent_dest[i] == src1) hazard1 = 1'b1;
         if (occ[i] && ent_dest[i] == src2) hazard2 = 1'b1;
      end
   end

   assign WB_EN    = wb_en_q;
   assign WB_Dest  = wb_dest_q;
   assign WB_Value = wb_value_q;
endmodule
